branch_resolve_predict: RTL

- Next-generation branch unit for the RISC-V pipeline.
- Resolves all conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and jumps in EX, compares the outcome against the IF-stage prediction, and issues a registered flush/redirect only on mispredict.
- Holds a parametrised branch history table (BHT) of 2-bit saturating counters that IF queries combinationally.
- Keeps wrapping performance counters for branches and mispredicts.

---
 rtl/branch_pkg.sv | 31 +++
 rtl/branch_bht.sv | 45 ++++
 rtl/branch_resolve_predict.sv | 117 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolve/predict unit:
// funct3 condition codes and the 2-bit saturating BHT counter.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  // Saturating step toward the observed outcome.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken && (ctr != CTR_ST)) begin
      res = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one clocked read-modify-write update port.
module branch_bht
  import branch_pkg::*;
#(
  parameter  int BHT_ENTRIES = 64,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t ctr_q [BHT_ENTRIES];
  bht_ctr_t ctr_d [BHT_ENTRIES];

  always_comb begin
    for (int i = 0; i < BHT_ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (wr_en) begin
      ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Reads see the stored value, so a same-cycle update is not forwarded.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch/jump resolution with a registered redirect on mispredict,
// a BHT for IF-stage prediction, and wrapping performance counters.
module branch_resolve_predict
  import branch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR     = 32'h8000_0000,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BHT_ENTRIES = 64,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_pred_taken,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_WIDTH-1:0] ex_rs1,
  input  logic [DATA_WIDTH-1:0] ex_rs2,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

  logic     cond;
  logic     cond_legal;
  logic     act;
  logic     taken;
  logic     bht_we;
  logic     mispredict;
  bht_ctr_t if_ctr;

  always_comb begin
    cond       = 1'b0;
    cond_legal = 1'b1;
    case (ex_funct3)
      F3_BEQ:  cond = (ex_rs1 == ex_rs2);
      F3_BNE:  cond = (ex_rs1 != ex_rs2);
      F3_BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: cond = (ex_rs1 <  ex_rs2);
      F3_BGEU: cond = (ex_rs1 >= ex_rs2);
      default: cond_legal = 1'b0;
    endcase
  end

  // The instruction in EX during a flush cycle is wrong-path and must not act.
  assign act        = ex_valid & ~flush_q & (ex_is_branch | ex_is_jump);
  assign taken      = ex_is_jump | (ex_is_branch & cond);
  assign bht_we     = act & ex_is_branch & ~ex_is_jump & cond_legal;
  assign mispredict = act & (taken != ex_pred_taken);

  always_comb begin
    flush_d            = mispredict;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict) begin
      redirect_pc_d      = taken ? ex_target : (ex_pc + ADDR_WIDTH'(4));
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
    end
    if (bht_we) begin
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q            <= 1'b0;
      redirect_pc_q      <= PC_ADDR;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      flush_q            <= flush_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  branch_bht #(
    .BHT_ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (if_pc[IDX_W+1:2]),
    .rd_ctr  (if_ctr),
    .wr_en   (bht_we),
    .wr_idx  (ex_pc[IDX_W+1:2]),
    .wr_taken(taken)
  );

  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[ADDR_WIDTH-1:IDX_W+2], if_pc[1:0]};

  assign if_pred_taken    = if_ctr[1];
  assign flush            = flush_q;
  assign redirect_valid   = flush_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
